// File: rtl/button_code_collector_pkg.sv
// Shared lock definitions: entry-state encodings, the clog2 helper and the default code length.
package button_code_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2
  } code_state_e;

  localparam int DEFAULT_DIGITS = 4;

  // Ceiling log2 that never returns less than 1, so single-value fields keep a bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/button_code_collector_onehot_index_encoder.sv
// Combinational press-vector encoder: index of the lowest set bit, plus any/multi flags.
module onehot_index_encoder
  import button_code_collector_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             any,
  output logic             multi
);

  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
  end

  assign any   = |vec;
  assign multi = (vec & (vec - WIDTH'(1))) != '0;

endmodule

// File: rtl/button_code_collector.sv
// Assembles button press pulses into a DIGITS-long code presented via valid/ack.
// Optional inactivity timeout is built when BUTTON_CODE_TIMEOUT_EN is defined.
module button_code_collector
  import button_code_collector_pkg::*;
#(
  parameter  int WIDTH          = 4,
  parameter  int DIGITS         = DEFAULT_DIGITS,
  parameter  int TIMEOUT_CYCLES = 50_000_000,
  localparam int IDX_W          = clog2_min1(WIDTH),
  localparam int CNT_W          = clog2_min1(DIGITS + 1),
  localparam int CODE_W         = DIGITS * IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  buttonEdge,
  input  logic              codeAck,
  output logic [CODE_W-1:0] code,
  output logic              codeValid,
  output logic              codeError,
  output logic [CNT_W-1:0]  digitCount,
  output logic              entryTimeout
);

  if (WIDTH < 1 || DIGITS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("button_code_collector: WIDTH, DIGITS and TIMEOUT_CYCLES must be positive");
  end

  logic [IDX_W-1:0] press_idx;
  logic             press_any;
  logic             press_multi;
  logic [IDX_W-1:0] digit;

  onehot_index_encoder #(.WIDTH(WIDTH)) u_encoder (
    .vec   (buttonEdge),
    .index (press_idx),
    .any   (press_any),
    .multi (press_multi)
  );

  // A multi-button press still consumes a digit slot, recorded as 0.
  assign digit = press_multi ? '0 : press_idx;

  code_state_e       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;

`ifdef BUTTON_CODE_TIMEOUT_EN
  localparam int TO_W = clog2_min1(TIMEOUT_CYCLES);
  logic [TO_W-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    error_d   = error_q;
    err_d     = err_q;
    timeout_d = 1'b0;
`ifdef BUTTON_CODE_TIMEOUT_EN
    idle_d    = '0;
`endif
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (press_any) begin
          code_d = (code_q << IDX_W) | CODE_W'(digit);
          cnt_d  = cnt_q + CNT_W'(1);
          err_d  = err_q | press_multi;
          if (cnt_q == CNT_W'(DIGITS - 1)) begin
            state_d = ST_PRESENT;
            valid_d = 1'b1;
            error_d = err_d;
          end else begin
            state_d = ST_COLLECT;
          end
        end
`ifdef BUTTON_CODE_TIMEOUT_EN
        else if (state_q == ST_COLLECT) begin
          if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_IDLE;
            code_d    = '0;
            cnt_d     = '0;
            err_d     = 1'b0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + TO_W'(1);
          end
        end
`endif
      end
      ST_PRESENT: begin
        // Presses are ignored here; an ack in the same cycle wins.
        if (codeAck) begin
          state_d = ST_IDLE;
          code_d  = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          error_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
`ifdef BUTTON_CODE_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
`ifdef BUTTON_CODE_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign code         = code_q;
  assign codeValid    = valid_q;
  assign codeError    = error_q;
  assign digitCount   = cnt_q;
`ifdef BUTTON_CODE_TIMEOUT_EN
  assign entryTimeout = timeout_q;
`else
  assign entryTimeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_button_code_collector.sv
// Directed bench for button_code_collector (WIDTH=4, DIGITS=4, TIMEOUT_CYCLES=16).
module tb_button_code_collector;

  localparam int WIDTH  = 4;
  localparam int DIGITS = 4;
  localparam int TOUT   = 16;

`ifdef BUTTON_CODE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] buttonEdge;
  logic       codeAck;
  logic [7:0] code;
  logic       codeValid;
  logic       codeError;
  logic [2:0] digitCount;
  logic       entryTimeout;

  int checks = 0;
  int passes = 0;

  button_code_collector #(
    .WIDTH          (WIDTH),
    .DIGITS         (DIGITS),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .buttonEdge   (buttonEdge),
    .codeAck      (codeAck),
    .code         (code),
    .codeValid    (codeValid),
    .codeError    (codeError),
    .digitCount   (digitCount),
    .entryTimeout (entryTimeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] vec);
    buttonEdge = vec;
    tick();
    buttonEdge = '0;
  endtask

  int pulses;

  initial begin
    reset      = 1'b1;
    buttonEdge = '0;
    codeAck    = 1'b0;
    #2 reset   = 1'b0;
    #1;
    check("rst_code", 32'(code), 32'h00);
    check("rst_valid", 32'(codeValid), 32'd0);
    check("rst_count", 32'(digitCount), 32'd0);
    check("rst_timeout", 32'(entryTimeout), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Basic entry 2,0,3,1 with gaps between presses
    press(4'b0100);
    check("d1_count", 32'(digitCount), 32'd1);
    check("d1_code", 32'(code), 32'h02);
    tick();
    press(4'b0001);
    tick();
    press(4'b1000);
    check("d3_valid", 32'(codeValid), 32'd0);
    check("d3_count", 32'(digitCount), 32'd3);
    press(4'b0010);
    check("d4_valid", 32'(codeValid), 32'd1);
    check("d4_code", 32'(code), 32'h8D);
    check("d4_error", 32'(codeError), 32'd0);
    check("d4_count", 32'(digitCount), 32'd4);

    // Presses ignored while presenting; ack wins over a same-cycle press
    press(4'b1000);
    check("pres_code_hold", 32'(code), 32'h8D);
    check("pres_count_hold", 32'(digitCount), 32'd4);
    codeAck    = 1'b1;
    buttonEdge = 4'b0010;
    tick();
    codeAck    = 1'b0;
    buttonEdge = '0;
    check("ack_valid", 32'(codeValid), 32'd0);
    check("ack_code", 32'(code), 32'h00);
    check("ack_count", 32'(digitCount), 32'd0);
    tick();
    check("ack_press_dropped", 32'(digitCount), 32'd0);

    // Multi-hot press as digit 2 -> error, digit recorded as 0
    press(4'b0010);
    press(4'b0101);
    press(4'b0100);
    press(4'b1000);
    check("err_valid", 32'(codeValid), 32'd1);
    check("err_code", 32'(code), 32'h4B);
    check("err_flag", 32'(codeError), 32'd1);

    // Press on the cycle right after the ack edge starts a new entry
    codeAck = 1'b1;
    tick();
    codeAck = 1'b0;
    check("ack2_error_clr", 32'(codeError), 32'd0);
    press(4'b1000);
    check("next_d1_count", 32'(digitCount), 32'd1);
    check("next_d1_code", 32'(code), 32'h03);
    check("next_d1_valid", 32'(codeValid), 32'd0);
    press(4'b0001);
    check("to_pre_count", 32'(digitCount), 32'd2);

    // Inactivity: 16 idle cycles with two digits held
    pulses = 0;
    for (int i = 0; i < TOUT; i++) begin
      tick();
      if (entryTimeout) pulses++;
      if (i == TOUT - 2) check("to_before_limit", 32'(digitCount), 32'd2);
    end
    check("to_pulses", 32'(pulses), TO_EN ? 32'd1 : 32'd0);
    check("to_count", 32'(digitCount), TO_EN ? 32'd0 : 32'd2);
    check("to_code", 32'(code), TO_EN ? 32'h00 : 32'h0C);
    tick();
    check("to_pulse_width", 32'(entryTimeout), 32'd0);

    // Asynchronous reset between edges while mid-entry
    press(4'b0100);
    check("mid_count", 32'(digitCount), TO_EN ? 32'd1 : 32'd3);
    #3 reset = 1'b0;
    #1;
    check("async_code", 32'(code), 32'h00);
    check("async_count", 32'(digitCount), 32'd0);
    check("async_valid", 32'(codeValid), 32'd0);
    check("async_error", 32'(codeError), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Back-to-back pulses 1,2,3,0
    buttonEdge = 4'b0010; tick();
    buttonEdge = 4'b0100; tick();
    buttonEdge = 4'b1000; tick();
    check("b2b_d3_valid", 32'(codeValid), 32'd0);
    check("b2b_d3_count", 32'(digitCount), 32'd3);
    buttonEdge = 4'b0001; tick();
    buttonEdge = '0;
    check("b2b_valid", 32'(codeValid), 32'd1);
    check("b2b_code", 32'(code), 32'h6C);
    check("b2b_error", 32'(codeError), 32'd0);
    check("b2b_count", 32'(digitCount), 32'd4);
    codeAck = 1'b1;
    tick();
    codeAck = 1'b0;
    check("final_valid", 32'(codeValid), 32'd0);
    check("final_code", 32'(code), 32'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
